// File: rtl/nearest_decimation.sv
// Nearest-neighbour YCbCr frame downscaler.
// Picks source pixels on a Q.16 grid, one cycle from input to output.
module nearest_decimation #(
  parameter logic [10:0] C_SRC_IMG_WIDTH  = 11'd1600,
  parameter logic [10:0] C_SRC_IMG_HEIGHT = 11'd900,
  parameter logic [10:0] C_DST_IMG_WIDTH  = 11'd640,
  parameter logic [10:0] C_DST_IMG_HEIGHT = 11'd480,
  parameter logic [19:0] C_X_RATIO        = 20'd163840,
  parameter logic [19:0] C_Y_RATIO        = 20'd122880
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  input  logic [7:0] per_img_Cb,
  input  logic [7:0] per_img_Cr,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_Y,
  output logic [7:0] post_img_Cb,
  output logic [7:0] post_img_Cr,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        vs_prev_q;
  logic        href_prev_q;
  logic [10:0] src_x_q, src_x_d;
  logic [10:0] src_y_q, src_y_d;
  logic [10:0] dst_x_q, dst_x_d;
  logic [10:0] dst_y_q, dst_y_d;
  logic [27:0] acc_x_q, acc_x_d;
  logic [27:0] acc_y_q, acc_y_d;

  logic       vsync_q, href_q, clken_q, done_q;
  logic [7:0] y_q, cb_q, cr_q;

  logic vs_rise, line_end, pix_in;
  logic row_sel, col_hit;
  logic active, pix_sel, last_line;

  assign vs_rise  = per_frame_vsync & ~vs_prev_q;
  assign line_end = href_prev_q & ~per_frame_href;
  assign pix_in   = per_frame_href & per_frame_clken;

  assign row_sel = ({1'b0, src_y_q} == acc_y_q[27:16])
                 && (dst_y_q < C_DST_IMG_HEIGHT);
  assign col_hit = ({1'b0, src_x_q} == acc_x_q[27:16])
                 && (dst_x_q < C_DST_IMG_WIDTH);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_VS;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_VS: if (vs_rise) state_d = ACTIVE;
      ACTIVE: begin
        if (vs_rise)        state_d = ACTIVE;
        else if (last_line) state_d = DONE;
      end
      DONE:    if (vs_rise) state_d = ACTIVE;
      default: state_d = WAIT_VS;
    endcase
  end

  // state outputs
  always_comb begin
    active    = (state_q == ACTIVE);
    pix_sel   = active & ~vs_rise & pix_in & row_sel & col_hit;
    last_line = active & ~vs_rise & line_end & row_sel
              & (dst_y_q == C_DST_IMG_HEIGHT - 11'd1);
  end

  // source/destination counters and sampling grid
  always_comb begin
    src_x_d = src_x_q;
    src_y_d = src_y_q;
    dst_x_d = dst_x_q;
    dst_y_d = dst_y_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    if (vs_rise) begin
      src_x_d = '0;
      src_y_d = '0;
      dst_x_d = '0;
      dst_y_d = '0;
      acc_x_d = '0;
      acc_y_d = '0;
    end else if (active) begin
      if (line_end) begin
        src_x_d = '0;
        dst_x_d = '0;
        acc_x_d = '0;
        if (src_y_q != C_SRC_IMG_HEIGHT)
          src_y_d = src_y_q + 11'd1;
        if (row_sel) begin
          acc_y_d = acc_y_q + {8'd0, C_Y_RATIO};
          dst_y_d = dst_y_q + 11'd1;
        end
      end else if (pix_in) begin
        if (src_x_q != C_SRC_IMG_WIDTH)
          src_x_d = src_x_q + 11'd1;
        if (pix_sel) begin
          acc_x_d = acc_x_q + {8'd0, C_X_RATIO};
          dst_x_d = dst_x_q + 11'd1;
        end
      end
    end
  end

  // edge detector resets high so a frame already in flight is skipped
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q   <= 1'b1;
      href_prev_q <= 1'b0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
    end else begin
      vs_prev_q   <= per_frame_vsync;
      href_prev_q <= per_frame_href;
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      dst_x_q     <= dst_x_d;
      dst_y_q     <= dst_y_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      clken_q <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      cb_q    <= '0;
      cr_q    <= '0;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href & active & row_sel;
      clken_q <= pix_sel;
      done_q  <= last_line;
      if (pix_sel) begin
        y_q  <= per_img_Y;
        cb_q <= per_img_Cb;
        cr_q <= per_img_Cr;
      end
    end
  end

  assign post_frame_vsync = vsync_q;
  assign post_frame_href  = href_q;
  assign post_frame_clken = clken_q;
  assign post_img_Y       = y_q;
  assign post_img_Cb      = cb_q;
  assign post_img_Cr      = cr_q;
  assign frame_done       = done_q;

endmodule
